// File: rtl/log_compress.sv
// Fixed-point log2 of an unsigned envelope magnitude, computed by iterative
// leading-one normalisation. The fraction bits are the mantissa bits below the leading one.
module log_compress #(
  parameter int unsigned ENV_WIDTH = 32,
  parameter int unsigned LOG_WIDTH = 16,
  parameter int unsigned FRAC_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ENV_WIDTH-1:0] env_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOG_WIDTH-1:0] log_out
);

  localparam int unsigned CNT_W = $clog2(ENV_WIDTH);
  localparam int unsigned INT_W = LOG_WIDTH - FRAC_BITS;

  typedef enum logic [1:0] {IDLE, NORM, PACK, SEND} state_t;

  state_t               state_q, state_d;
  logic [ENV_WIDTH-1:0] mant_q, mant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LOG_WIDTH-1:0] log_q, log_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic [INT_W-1:0]     int_part;

  // The integer part is the bit position of the leading one.
  assign int_part = INT_W'(ENV_WIDTH - 1) - INT_W'(cnt_q);

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    cnt_d       = cnt_q;
    log_d       = log_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mant_d     = env_in;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = (env_in == '0) ? PACK : NORM;
        end
      end
      NORM: begin
        if (mant_q[ENV_WIDTH-1]) begin
          state_d = PACK;
        end else begin
          mant_d = mant_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      PACK: begin
        // A mantissa that is still zero here can only come from a zero input.
        if (mant_q[ENV_WIDTH-1]) begin
          log_d = LOG_WIDTH'({int_part, mant_q[ENV_WIDTH-2 -: FRAC_BITS]});
        end else begin
          log_d = '0;
        end
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      cnt_q       <= '0;
      log_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      cnt_q       <= cnt_d;
      log_q       <= log_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign log_out   = log_q;

endmodule

// File: tb/tb_log_compress.sv
// Self-checking bench for log_compress: directed vectors, reset and backpressure
// sequences, and a randomized handshake stream against a reference model.
module tb_log_compress;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] env_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] log_out;

  int total;
  int bad;

  log_compress #(.ENV_WIDTH(32), .LOG_WIDTH(16), .FRAC_BITS(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .env_in   (env_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .log_out  (log_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] env;
    logic [15:0] exp_log;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] env;
    logic [15:0] lg;
  } pair_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Independent reference: position of the leading one, then the next 11 bits.
  function automatic logic [15:0] ref_log(input logic [31:0] x);
    logic [31:0] n;
    int p;
    if (x == 32'd0) return 16'd0;
    p = 31;
    while (!x[p]) p--;
    n = x << (31 - p);
    return {5'(p), n[30:20]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one sample with out_ready=1, then check latency, value and return to idle.
  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin tick(); guard++; end
    check({name, "_ready_wait"}, 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    env_in    = v.env;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    check({name, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    check({name, "_log"}, 32'(log_out), 32'(v.exp_log));
    tick();
    check({name, "_idle_after"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  // Random-stream scoreboard
  logic [15:0] exp_q[$];
  pair_t       pairs[$];
  logic [31:0] acc_env_q[$];
  bit          mon_en;
  int          rx_cnt;
  int          dup_err;
  int          both_err;

  always @(posedge clk) begin
    if (mon_en) begin
      if (in_ready && out_valid) both_err++;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_log(env_in));
        acc_env_q.push_back(env_in);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          dup_err++;
        end else begin
          pair_t pr;
          check("stream_log", 32'(log_out), 32'(exp_q[0]));
          pr.env = acc_env_q[0];
          pr.lg  = log_out;
          pairs.push_back(pr);
          void'(exp_q.pop_front());
          void'(acc_env_q.pop_front());
        end
        rx_cnt++;
      end
    end
  end

  localparam int N_RAND = 1000;

  initial begin
    vec_t vecs[8];
    logic [15:0] held;
    int guard;
    int viol;

    total = 0; bad = 0;
    mon_en = 1'b0; rx_cnt = 0; dup_err = 0; both_err = 0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; env_in = 32'd0;

    vecs[0] = '{32'h0001_0000, 16'h8000, 17};
    vecs[1] = '{32'h0000_0003, 16'h0C00, 32};
    vecs[2] = '{32'hFFFF_FFFF, 16'hFFFF, 2};
    vecs[3] = '{32'h8000_0000, 16'hF800, 2};
    vecs[4] = '{32'h0000_0000, 16'h0000, 1};
    vecs[5] = '{32'h0000_0001, 16'h0000, 33};
    vecs[6] = '{32'h0000_0800, 16'h5800, 22};
    vecs[7] = '{32'h1234_5678, 16'hE11A, 5};

    tick(); tick();
    check("reset_values", {15'd0, in_ready, out_valid, log_out}, {15'd0, 1'b1, 1'b0, 16'h0000});
    reset = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of normalising env_in=1.
    in_valid = 1'b1; env_in = 32'h0000_0001;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("midreset_async", {15'd0, in_ready, out_valid, log_out}, {15'd0, 1'b1, 1'b0, 16'h0000});
    tick();
    reset = 1'b1;
    viol = 0;
    for (int c = 0; c < 40; c++) begin tick(); if (out_valid) viol++; end
    check("midreset_no_output", 32'(viol), 32'd0);
    run_vec('{32'h0000_0100, 16'h4000, 25}, "post_reset");

    // Backpressure: output held while a new sample waits upstream.
    out_ready = 1'b0;
    in_valid = 1'b1; env_in = 32'h0001_0000;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin tick(); guard++; end
    check("bp_first_valid", 32'(out_valid), 32'd1);
    held = log_out;
    check("bp_first_log", 32'(held), 32'h8000);
    in_valid = 1'b1; env_in = 32'h0000_0005;
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (log_out !== 16'h8000 || in_ready || !out_valid) viol++;
    end
    check("bp_hold_stable", 32'(viol), 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_handshake", {30'd0, out_valid, in_ready}, 32'b01);
    tick();
    check("bp_new_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin tick(); guard++; end
    check("bp_second_log", 32'(log_out), 32'h1200);
    tick();

    // Random stream with random valid/ready on both sides.
    mon_en = 1'b1;
    fork
      begin
        for (int s = 0; s < N_RAND; s++) begin
          logic r;
          int g;
          logic [31:0] e;
          e = $urandom >> $urandom_range(0, 32);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          in_valid = 1'b1;
          env_in = e;
          g = 0;
          r = 1'b0;
          while (!r && g < 500) begin r = in_ready; tick(); g++; end
          in_valid = 1'b0;
        end
      end
      begin
        int g;
        g = 0;
        while (rx_cnt < N_RAND && g < 80000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          g++;
        end
        out_ready = 1'b1;
      end
    join
    tick(); tick();
    mon_en = 1'b0;
    check("stream_count", 32'(rx_cnt), 32'(N_RAND));
    check("stream_leftover", 32'(exp_q.size()), 32'd0);
    check("stream_dup", 32'(dup_err), 32'd0);
    check("stream_ready_valid_excl", 32'(both_err), 32'd0);

    viol = 0;
    for (int i = 0; i < pairs.size(); i++)
      for (int j = 0; j < pairs.size(); j++)
        if (pairs[i].env < pairs[j].env && pairs[i].lg > pairs[j].lg) viol++;
    check("stream_monotonic", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
